// File: rtl/vga_compositor.sv
// VGA timing generator and N-layer priority compositor.
// Timing runs from the system clock with a one-in-CLK_DIV pixel enable.
// Layer enables come from a per-scene table that is sampled only at frame start.
// The composite pixel and both syncs leave the block registered and mutually aligned.
module vga_compositor #(
    parameter int N_LAYERS = 4,
    parameter int PIX_W    = 12,
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 2,
    parameter int SCENE_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SCENE_W-1:0]        scene,
    input  logic                      mask_wr,
    input  logic [SCENE_W-1:0]        mask_addr,
    input  logic [N_LAYERS-1:0]       mask_data,
    input  logic [N_LAYERS-1:0]       layer_valid,
    input  logic [N_LAYERS*PIX_W-1:0] layer_pixel,
    input  logic [PIX_W-1:0]          bg_pixel,
    output logic                      pix_en,
    output logic [9:0]                h_cnt,
    output logic [9:0]                v_cnt,
    output logic                      frame_start,
    output logic [PIX_W-1:0]          vga_rgb,
    output logic                      hsync,
    output logic                      vsync
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TBL_DEPTH = 2 ** SCENE_W;

    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_MAX     = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_MAX     = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT_END = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0]       H_SYN_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       H_SYN_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]       V_SYN_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       V_SYN_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]    div_r;
    logic [DIV_W-1:0]    div_nxt_s;
    logic                pix_en_nxt_s;
    logic                pix_en_r;
    logic [9:0]          h_cnt_r;
    logic [9:0]          v_cnt_r;
    logic [9:0]          h_nxt_s;
    logic [9:0]          v_nxt_s;
    logic                frame_start_r;

    logic [N_LAYERS-1:0] tbl_r [TBL_DEPTH];
    logic [N_LAYERS-1:0] active_mask_r;

    logic                hs_raw_s;
    logic                vs_raw_s;
    logic                act_raw_s;
    logic [PIPE_LAT:0]   hs_dl_r;
    logic [PIPE_LAT:0]   vs_dl_r;
    logic [PIPE_LAT:0]   act_dl_r;

    logic [PIX_W-1:0]    comp_s;
    logic [PIX_W-1:0]    vga_rgb_r;

    // Next divider count and whether the next cycle is a pixel-enable cycle.
    always_comb begin
        div_nxt_s = div_r;
        if (div_r == DIV_MAX) begin
            div_nxt_s = '0;
        end else begin
            div_nxt_s = div_r + DIV_W'(1);
        end
        pix_en_nxt_s = (div_nxt_s == DIV_MAX);
    end

    // Next raster position; it only moves on pixel-enable cycles.
    always_comb begin
        h_nxt_s = h_cnt_r;
        v_nxt_s = v_cnt_r;
        if (pix_en_r) begin
            if (h_cnt_r == H_MAX) begin
                h_nxt_s = 10'd0;
                if (v_cnt_r == V_MAX) begin
                    v_nxt_s = 10'd0;
                end else begin
                    v_nxt_s = v_cnt_r + 10'd1;
                end
            end else begin
                h_nxt_s = h_cnt_r + 10'd1;
            end
        end else begin
            h_nxt_s = h_cnt_r;
            v_nxt_s = v_cnt_r;
        end
    end

    // Divider, raster counters and the registered pix_en / frame_start pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r         <= '0;
            pix_en_r      <= 1'b0;
            h_cnt_r       <= 10'd0;
            v_cnt_r       <= 10'd0;
            frame_start_r <= 1'b0;
        end else begin
            div_r         <= div_nxt_s;
            pix_en_r      <= pix_en_nxt_s;
            h_cnt_r       <= h_nxt_s;
            v_cnt_r       <= v_nxt_s;
            frame_start_r <= pix_en_nxt_s && (h_nxt_s == H_MAX) && (v_nxt_s == V_MAX);
        end
    end

    // Scene layer-enable table; writes land immediately but are only consumed at frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                tbl_r[i] <= '1;
            end
        end else if (mask_wr) begin
            tbl_r[mask_addr] <= mask_data;
        end else begin
            tbl_r[mask_addr] <= tbl_r[mask_addr];
        end
    end

    // Frame-coherent mask: latch the pre-write table entry of the current scene at frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_mask_r <= '1;
        end else if (frame_start_r) begin
            active_mask_r <= tbl_r[scene];
        end else begin
            active_mask_r <= active_mask_r;
        end
    end

    // Undelayed sync and active-area flags for the presented raster position.
    always_comb begin
        hs_raw_s  = !((h_cnt_r >= H_SYN_BEG) && (h_cnt_r < H_SYN_END));
        vs_raw_s  = !((v_cnt_r >= V_SYN_BEG) && (v_cnt_r < V_SYN_END));
        act_raw_s = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
    end

    // Priority select: scanning from the lowest priority up lets layer 0 win last.
    always_comb begin
        comp_s = bg_pixel;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            comp_s = (layer_valid[k] && active_mask_r[k]) ? layer_pixel[k*PIX_W +: PIX_W] : comp_s;
        end
    end

    // Delay lines matching the external renderer latency plus the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_dl_r   <= '1;
            vs_dl_r   <= '1;
            act_dl_r  <= '0;
            vga_rgb_r <= '0;
        end else if (pix_en_r) begin
            hs_dl_r   <= {hs_dl_r[PIPE_LAT-1:0], hs_raw_s};
            vs_dl_r   <= {vs_dl_r[PIPE_LAT-1:0], vs_raw_s};
            act_dl_r  <= {act_dl_r[PIPE_LAT-1:0], act_raw_s};
            vga_rgb_r <= act_dl_r[PIPE_LAT-1] ? comp_s : '0;
        end else begin
            hs_dl_r   <= hs_dl_r;
            vs_dl_r   <= vs_dl_r;
            act_dl_r  <= act_dl_r;
            vga_rgb_r <= vga_rgb_r;
        end
    end

    assign pix_en      = pix_en_r;
    assign h_cnt       = h_cnt_r;
    assign v_cnt       = v_cnt_r;
    assign frame_start = frame_start_r;
    assign vga_rgb     = vga_rgb_r;
    assign hsync       = hs_dl_r[PIPE_LAT];
    assign vsync       = vs_dl_r[PIPE_LAT];

endmodule

// File: tb/tb_vga_compositor.sv
// Bench for vga_compositor using a shrunken raster so several frames fit in a short run.
// Expected outputs come from a tick-count model of the raster and the compositing rules.
module tb_vga_compositor;

    localparam int N  = 4;
    localparam int PW = 12;
    localparam int CD = 4;
    localparam int HA = 20, HF = 4, HS = 6, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int PL = 2;
    localparam int SW = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * CD;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] scene;
    logic          mask_wr;
    logic [SW-1:0] mask_addr;
    logic [N-1:0]  mask_data;
    logic [N-1:0]  layer_valid;
    logic [N*PW-1:0] layer_pixel;
    logic [PW-1:0] bg_pixel;
    logic          pix_en;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          frame_start;
    logic [PW-1:0] vga_rgb;
    logic          hsync;
    logic          vsync;

    vga_compositor #(
        .N_LAYERS(N), .PIX_W(PW), .CLK_DIV(CD),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_LAT(PL), .SCENE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .scene(scene),
        .mask_wr(mask_wr), .mask_addr(mask_addr), .mask_data(mask_data),
        .layer_valid(layer_valid), .layer_pixel(layer_pixel), .bg_pixel(bg_pixel),
        .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_start(frame_start),
        .vga_rgb(vga_rgb), .hsync(hsync), .vsync(vsync)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int            cyc;
    int            tick;
    int            fs_cnt;
    logic [N-1:0]  tbl [2**SW];
    logic [N-1:0]  amask;
    logic [PW-1:0] exp_rgb;
    logic          exp_hs;
    logic          exp_vs;
    logic          out_act;
    int            mode;
    bit            wr_req;
    bit            fs_wr_req;
    logic [N-1:0]  wr_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pick(input logic [N-1:0] v, input logic [N*PW-1:0] px,
                                           input logic [N-1:0] m, input logic [PW-1:0] bg);
        logic [PW-1:0] r;
        bit found;
        r = bg;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && v[k] && m[k]) begin
                r = px[k*PW +: PW];
                found = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        cyc = 0;
        tick = 0;
        fs_cnt = 0;
        for (int i = 0; i < 2**SW; i++) tbl[i] = '1;
        amask = '1;
        exp_rgb = '0;
        exp_hs = 1'b1;
        exp_vs = 1'b1;
        out_act = 1'b0;
    endtask

    // Check the current cycle, drive the next inputs, advance the model by one clock.
    task automatic step();
        logic ep, efs, ain;
        int eh, ev, c, ch, cv;
        ep  = (cyc % CD) == CD - 1;
        eh  = tick % HT;
        ev  = (tick / HT) % VT;
        efs = ep && (eh == HT - 1) && (ev == VT - 1);
        check("pix_en", 32'(pix_en), 32'(ep));
        check("h_cnt", 32'(h_cnt), eh);
        check("v_cnt", 32'(v_cnt), ev);
        check("frame_start", 32'(frame_start), 32'(efs));
        check("vga_rgb", 32'(vga_rgb), 32'(exp_rgb));
        check("hsync", 32'(hsync), 32'(exp_hs));
        check("vsync", 32'(vsync), 32'(exp_vs));

        if (mode == 0) begin
            scene       = SW'($urandom());
            layer_valid = N'($urandom());
            layer_pixel = (N*PW)'({$urandom(), $urandom()});
            bg_pixel    = PW'($urandom());
            mask_data   = N'($urandom());
            if (efs) begin
                mask_wr   = 1'($urandom_range(0, 1));
                mask_addr = scene;
            end else begin
                mask_wr   = ($urandom_range(0, 15) == 0);
                mask_addr = SW'($urandom());
            end
        end else begin
            scene       = 3'd2;
            layer_valid = 4'b0110;
            layer_pixel = 48'h444_333_222_111;
            bg_pixel    = 12'h0F0;
            mask_addr   = 3'd2;
            mask_data   = wr_data;
            mask_wr     = 1'b0;
            if (wr_req) begin
                mask_wr = 1'b1;
                wr_req  = 1'b0;
            end else if (fs_wr_req && efs) begin
                mask_wr   = 1'b1;
                fs_wr_req = 1'b0;
            end
        end

        if (ep) begin
            c = tick - PL;
            if (c < 0) begin
                exp_rgb = '0;
                exp_hs  = 1'b1;
                exp_vs  = 1'b1;
                out_act = 1'b0;
            end else begin
                ch  = c % HT;
                cv  = (c / HT) % VT;
                ain = (ch < HA) && (cv < VA);
                out_act = ain;
                exp_rgb = ain ? pick(layer_valid, layer_pixel, amask, bg_pixel) : '0;
                exp_hs  = !((ch >= HA + HF) && (ch < HA + HF + HS));
                exp_vs  = !((cv >= VA + VF) && (cv < VA + VF + VS));
            end
            tick++;
        end
        if (efs) begin
            amask = tbl[scene];
            fs_cnt++;
        end
        if (mask_wr) tbl[mask_addr] = mask_data;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_clks(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the given number of frame starts has passed and the output is in the active area.
    task automatic wait_active(input int min_fs, input string tag);
        int n;
        n = 0;
        while (!(fs_cnt >= min_fs && out_act) && n < 3 * FRAME_CLKS) begin
            step();
            n++;
        end
        check({tag, "_reached"}, 32'(out_act && (fs_cnt >= min_fs)), 32'd1);
    endtask

    // Asynchronous reset mid-frame: outputs must drop immediately, then timing restarts at (0,0).
    task automatic reset_now(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_rgb"}, 32'(vga_rgb), 32'd0);
        check({tag, "_hs"}, 32'(hsync), 32'd1);
        check({tag, "_vs"}, 32'(vsync), 32'd1);
        check({tag, "_pix"}, 32'(pix_en), 32'd0);
        check({tag, "_h"}, 32'(h_cnt), 32'd0);
        check({tag, "_v"}, 32'(v_cnt), 32'd0);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int n;
        rst = 1'b0;
        scene = '0; mask_wr = 1'b0; mask_addr = '0; mask_data = '0;
        layer_valid = '0; layer_pixel = '0; bg_pixel = '0;
        mode = 0; wr_req = 1'b0; fs_wr_req = 1'b0; wr_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rgb", 32'(vga_rgb), 32'd0);
        check("rst_hs", 32'(hsync), 32'd1);
        check("rst_vs", 32'(vsync), 32'd1);
        check("rst_pix", 32'(pix_en), 32'd0);
        rst = 1'b1;

        // random traffic over several frames
        run_clks(3 * FRAME_CLKS);

        // reset while a non-black pixel is on the output
        n = 0;
        while (!(out_act && exp_rgb != '0) && n < FRAME_CLKS) begin step(); n++; end
        check("pre_rst1_rgb_nonzero", 32'(vga_rgb != '0), 32'd1);
        reset_now("rst1");
        run_clks(FRAME_CLKS / 2);

        // reset while hsync is low
        n = 0;
        while (exp_hs && n < FRAME_CLKS) begin step(); n++; end
        check("pre_rst2_hs_low", 32'(hsync), 32'd0);
        reset_now("rst2");

        // directed layering and frame-coherent mask updates (table is all-ones after reset)
        mode = 1;
        wait_active(0, "l1");
        check("dir_l1", 32'(vga_rgb), 32'h222);
        wr_data = 4'b0001;
        wr_req  = 1'b1;
        step();
        wait_active(0, "hold");
        check("dir_hold", 32'(vga_rgb), 32'h222);
        wait_active(1, "bg");
        check("dir_bg", 32'(vga_rgb), 32'h0F0);
        wr_data   = 4'b0100;
        fs_wr_req = 1'b1;
        wait_active(2, "fsw_old");
        check("dir_fsw_old", 32'(vga_rgb), 32'h0F0);
        wait_active(3, "fsw_new");
        check("dir_fsw_new", 32'(vga_rgb), 32'h333);

        // more random traffic
        mode = 0;
        run_clks(2 * FRAME_CLKS);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
